// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and constants for the direct-mapped byte cache.
//               Holds the controller state encoding, the default line geometry
//               and the saturating statistics-counter helper.
// Contents    : state_t, AWIDTH_DEF, IDX_BITS_DEF, TAG_BITS, LINES, CNT_W,
//               sat_inc()
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    // Default geometry: 9-bit byte address, 16 lines, 5-bit tag.
    localparam int AWIDTH_DEF   = 9;
    localparam int IDX_BITS_DEF = 4;
    localparam int TAG_BITS     = AWIDTH_DEF - IDX_BITS_DEF;
    localparam int LINES        = 1 << IDX_BITS_DEF;

    // Width of the read hit / read miss statistics counters.
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_FILL  = 3'd2,
        ST_WR_ISSUE = 3'd3,
        ST_WR_WAIT  = 3'd4
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_line_array.sv
`default_nettype none
// ============================================================================
// Module      : cache_line_array
// Description : Valid/tag/data storage for a direct-mapped cache with one byte
//               per line. Combinational lookup, a single write port that either
//               updates the data only or fills a whole line, and a synchronous
//               clear of every valid bit.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               i_clr           - clear all valid bits at this edge
//               i_we, i_fill    - write enable; fill also sets valid and tag
//               i_widx/_wtag/_wdata - write port
//               i_ridx          - lookup index
//               o_rvalid/_rtag/_rdata - lookup result
// Revision    : 1.0 - initial release
// ============================================================================
module cache_line_array
    import cache_pkg::*;
#(
    parameter int IDX_W  = IDX_BITS_DEF,
    parameter int TAG_W  = TAG_BITS,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic              i_fill,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [TAG_W-1:0]  i_wtag,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_ridx,
    output logic              o_rvalid,
    output logic [TAG_W-1:0]  o_rtag,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int N_LINES = 1 << IDX_W;

    logic [N_LINES-1:0] valid_q;
    logic [N_LINES-1:0] valid_d;
    logic [TAG_W-1:0]   tag_q  [N_LINES];
    logic [DATA_W-1:0]  data_q [N_LINES];

    // Clear is applied last so that a flush on the same edge as a fill
    // leaves the line invalid.
    always_comb begin
        valid_d = valid_q;
        if (i_we && i_fill) begin
            valid_d[i_widx] = 1'b1;
        end
        if (i_clr) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data payload carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (i_we) begin
            data_q[i_widx] <= i_wdata;
            if (i_fill) begin
                tag_q[i_widx] <= i_wtag;
            end
        end
    end

    assign o_rvalid = valid_q[i_ridx];
    assign o_rtag   = tag_q[i_ridx];
    assign o_rdata  = data_q[i_ridx];

endmodule
`default_nettype wire

// File: rtl/dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dm_cache_ctrl
// Description : Direct-mapped, write-through, no-write-allocate byte cache
//               between a processor load/store port and main_memory.
//               Read hits complete in one cycle; read misses fetch and fill;
//               every write goes to memory and updates the line on a hit.
// Ports       : clk, reset                       - clock, async active-high reset
//               cpu_req/_we/_addr/_wdata         - processor request
//               cpu_ready/_done/_rdata           - handshake and read data
//               cache_flush                      - invalidate all lines
//               rd_mem/wr_mem/addr_mem/data_in   - memory command side
//               data_out/ready_mem               - memory response side
//               hit_cnt/miss_cnt                 - saturating read statistics
// Revision    : 1.0 - initial release
// ============================================================================
module dm_cache_ctrl
    import cache_pkg::*;
#(
    parameter int AWIDTH   = AWIDTH_DEF,
    parameter int DWIDTH   = 8,
    parameter int IDX_BITS = IDX_BITS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic [DWIDTH-1:0] cpu_rdata,
    input  logic              cache_flush,
    output logic              rd_mem,
    output logic              wr_mem,
    output logic [AWIDTH-1:0] addr_mem,
    output logic [DWIDTH-1:0] data_in,
    input  logic [DWIDTH-1:0] data_out,
    input  logic              ready_mem,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int TAG_W = AWIDTH - IDX_BITS;

    state_t              state_q,    state_d;
    logic                done_q,     done_d;
    logic [DWIDTH-1:0]   rdata_q,    rdata_d;
    logic                rd_mem_q,   rd_mem_d;
    logic                wr_mem_q,   wr_mem_d;
    logic [AWIDTH-1:0]   addr_q,     addr_d;
    logic [DWIDTH-1:0]   wdat_q,     wdat_d;
    logic [CNT_W-1:0]    hit_cnt_q,  hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

    logic                w_lk_valid;
    logic [TAG_W-1:0]    w_lk_tag;
    logic [DWIDTH-1:0]   w_lk_data;
    logic                w_hit;
    logic                w_accept;

    logic                w_lw_we;
    logic                w_lw_fill;
    logic [IDX_BITS-1:0] w_lw_idx;
    logic [TAG_W-1:0]    w_lw_tag;
    logic [DWIDTH-1:0]   w_lw_data;

    cache_line_array #(
        .IDX_W  (IDX_BITS),
        .TAG_W  (TAG_W),
        .DATA_W (DWIDTH)
    ) u_lines (
        .clk      (clk),
        .rst      (reset),
        .i_clr    (cache_flush),
        .i_we     (w_lw_we),
        .i_fill   (w_lw_fill),
        .i_widx   (w_lw_idx),
        .i_wtag   (w_lw_tag),
        .i_wdata  (w_lw_data),
        .i_ridx   (cpu_addr[IDX_BITS-1:0]),
        .o_rvalid (w_lk_valid),
        .o_rtag   (w_lk_tag),
        .o_rdata  (w_lk_data)
    );

    // The done cycle blocks acceptance so every completion is separated
    // from the next request by at least one cycle.
    assign cpu_ready = (state_q == ST_IDLE) && ready_mem && !done_q;
    assign w_accept  = cpu_req && cpu_ready;
    assign w_hit     = w_lk_valid && (w_lk_tag == cpu_addr[AWIDTH-1:IDX_BITS]);

    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        rdata_d    = rdata_q;
        rd_mem_d   = 1'b0;
        wr_mem_d   = 1'b0;
        addr_d     = addr_q;
        wdat_d     = wdat_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        w_lw_we    = 1'b0;
        w_lw_fill  = 1'b0;
        w_lw_idx   = cpu_addr[IDX_BITS-1:0];
        w_lw_tag   = addr_q[AWIDTH-1:IDX_BITS];
        w_lw_data  = cpu_wdata;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!cpu_we) begin
                        if (w_hit) begin
                            rdata_d   = w_lk_data;
                            done_d    = 1'b1;
                            hit_cnt_d = sat_inc(hit_cnt_q);
                        end else begin
                            addr_d     = cpu_addr;
                            miss_cnt_d = sat_inc(miss_cnt_q);
                            rd_mem_d   = 1'b1;
                            state_d    = ST_RD_ISSUE;
                        end
                    end else begin
                        addr_d   = cpu_addr;
                        wdat_d   = cpu_wdata;
                        // Write hit refreshes the cached byte; a miss never allocates.
                        w_lw_we  = w_hit;
                        wr_mem_d = 1'b1;
                        state_d  = ST_WR_ISSUE;
                    end
                end
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_FILL;
            end
            ST_RD_FILL: begin
                w_lw_we   = 1'b1;
                w_lw_fill = 1'b1;
                w_lw_idx  = addr_q[IDX_BITS-1:0];
                w_lw_data = data_out;
                rdata_d   = data_out;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_WR_ISSUE: begin
                state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            done_q     <= 1'b0;
            rdata_q    <= '0;
            rd_mem_q   <= 1'b0;
            wr_mem_q   <= 1'b0;
            addr_q     <= '0;
            wdat_q     <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            rd_mem_q   <= rd_mem_d;
            wr_mem_q   <= wr_mem_d;
            addr_q     <= addr_d;
            wdat_q     <= wdat_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign cpu_done  = done_q;
    assign cpu_rdata = rdata_q;
    assign rd_mem    = rd_mem_q;
    assign wr_mem    = wr_mem_q;
    assign addr_mem  = addr_q;
    assign data_in   = wdat_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule
`default_nettype wire
